// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read/write port drivers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package afifo_pkg;

  // Default data width, shared by the write- and read-side drivers.
  localparam int AFIFO_DATA_WIDTH = 32;

  // Write-port driver states.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BURST = 2'd1,
    W_DONE  = 2'd2
  } wdrv_state_e;

endpackage : afifo_pkg

// File: rtl/afifo_wdriver_ctrl.sv
// Write-port driver for the async FIFO (wclk domain): moves a commanded burst of words from an
//   upstream valid/ready stream into the FIFO write port, with stall timeout and abort.
// Latency: first winc 1 cycle after start; done pulses the cycle after the last write.
// Backpressure: s_ready = ~wfull during a burst only; winc is never raised while wfull is high.
//
// Ports:
//   wclk, wrst_n         write clock, async active-low reset
//   start, len, abort    burst command (sampled in IDLE) and synchronous abort
//   s_valid/s_ready/s_data  upstream stream
//   wfull, winc, wdata   FIFO write port (wfull already synchronised to wclk)
//   busy, done, err, words  status: busy outside IDLE, one-cycle done, err with done, word count
module afifo_wdriver_ctrl
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = AFIFO_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8,
  parameter int STALL_MAX  = 1024
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  wdrv_state_e          state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [SW-1:0]        stall_cnt;
  logic                 xfer;

  // Write port decodes straight from state so a reset drops winc/s_ready at once.
  always_comb begin
    s_ready = 1'b0;
    winc    = 1'b0;
    xfer    = 1'b0;
    wdata   = s_data;
    if (state == W_BURST) begin
      s_ready = ~wfull;
      xfer    = s_valid & ~wfull;
      winc    = xfer;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= W_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      words     <= '0;
      remaining <= '0;
      stall_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        W_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            words <= '0;
            err   <= 1'b0;
            if (len != '0) begin
              state     <= W_BURST;
              remaining <= len;
              stall_cnt <= '0;
            end else begin
              // Empty burst completes immediately.
              state <= W_DONE;
              done  <= 1'b1;
            end
          end
        end

        W_BURST: begin
          if (xfer) begin
            words     <= words + LEN_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
          // Only a full FIFO counts as a stall; an idle upstream does not.
          if (wfull) stall_cnt <= stall_cnt + SW'(1);
          else       stall_cnt <= '0;

          // Final word wins over abort, abort wins over timeout.
          if (xfer && remaining == LEN_WIDTH'(1)) begin
            state <= W_DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else if (abort) begin
            state <= W_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (wfull && stall_cnt == STALL_LAST) begin
            state <= W_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end

        W_DONE: begin
          state <= W_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= W_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_no_write_when_full : assert property (@(posedge wclk) disable iff (!wrst_n) !(winc && wfull));

endmodule : afifo_wdriver_ctrl
